// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan controller: the hex glyph
// table, the dark segment pattern, and a width helper.
package seg_scan_pkg;

    // Segment patterns for hex 0..F, bit0=a .. bit6=g, active-high.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Bits needed to hold values 0..v-1. Always at least 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_hex7_decode.sv
// Combinational hex nibble to seven-segment glyph lookup.
module hex7_decode
    import seg_scan_pkg::*;
(
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: slot/digit counters, frame-synchronous
// display update, leading-zero blanking and registered digit/segment drive.
module seg_scan_ctrl
    import seg_scan_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 50000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   dig_sel,
    output logic                    frame_tick,
    output logic                    upd_pend
);

    localparam int CW = clog2(SCAN_DIV);
    localparam int IW = clog2(NUM_DIGITS);
    localparam int DW = 4 * NUM_DIGITS;
    localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [DW-1:0] disp;
    logic [DW-1:0] pending;
    logic          slot_end;
    logic          frame_end;
    logic          xfer;
    logic          lit;
    logic          lz_blank;
    logic          zero_acc;
    logic          cur_upper_zero;
    logic [3:0]    cur_nib;
    logic [6:0]    dec_seg;

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = enable && slot_end && (idx == IDX_MAX);
    // While stopped nothing is being scanned, so a pending word may land at once.
    assign xfer      = upd_pend && (frame_end || !enable);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (enable) begin
            if (slot_end) begin
                cnt <= '0;
                idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A load on the transfer edge keeps its new word pending for the next frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp     <= '0;
            pending  <= '0;
            upd_pend <= 1'b0;
        end else begin
            if (xfer) disp <= pending;
            if (load) pending <= value_in;
            if (load)      upd_pend <= 1'b1;
            else if (xfer) upd_pend <= 1'b0;
        end
    end

    // Select the active nibble and whether it and everything above it are zero.
    always_comb begin
        cur_nib        = 4'h0;
        cur_upper_zero = 1'b0;
        zero_acc       = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_acc = zero_acc && (disp[4*i +: 4] == 4'h0);
            if (idx == IW'(i)) begin
                cur_nib        = disp[4*i +: 4];
                cur_upper_zero = zero_acc;
            end
        end
    end

    hex7_decode u_dec (
        .nib (cur_nib),
        .seg (dec_seg)
    );

    assign lit      = enable && (32'(cnt) >= 32'(BLANK_CYC));
    assign lz_blank = blank_lz && (idx != '0) && cur_upper_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            dig_sel    <= '0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= frame_end;
            dig_sel    <= lit ? (NUM_DIGITS'(1) << idx) : '0;
            seg        <= (lit && !lz_blank) ? dec_seg : SEG_BLANK;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 4 digits, 8-clock slots and 2 blank clocks.
module tb_seg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value_in = '0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        frame_tick;
    logic        upd_pend;

    int vectors = 0;
    int miscompares = 0;
    int n77;
    int n7c;

    seg_scan_ctrl #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (8),
        .BLANK_CYC  (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .load       (load),
        .value_in   (value_in),
        .blank_lz   (blank_lz),
        .seg        (seg),
        .dig_sel    (dig_sel),
        .frame_tick (frame_tick),
        .upd_pend   (upd_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges, then settle on the following falling edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        enable = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("rst_seg",   16'(seg),        16'h00);
        check("rst_dig",   16'(dig_sel),    16'h0);
        check("rst_tick",  16'(frame_tick), 16'h0);
        check("rst_pend",  16'(upd_pend),   16'h0);
        @(negedge clk);
        rst = 1'b0;

        // Free-running scan of an all-zero display.
        step(1);  check("e1_dig",  16'(dig_sel), 16'h0);
                  check("e1_seg",  16'(seg),     16'h00);
        step(2);  check("e3_dig",  16'(dig_sel), 16'h1);
                  check("e3_seg",  16'(seg),     16'h3F);
        step(5);  check("e8_dig",  16'(dig_sel), 16'h1);
        step(1);  check("e9_dig",  16'(dig_sel), 16'h0);
        step(2);  check("e11_dig", 16'(dig_sel), 16'h2);
        step(21); check("e32_tick", 16'(frame_tick), 16'h1);
                  check("e32_dig",  16'(dig_sel),    16'h8);
        step(1);  check("e33_tick", 16'(frame_tick), 16'h0);

        // Mid-frame load waits for the boundary.
        load = 1'b1; value_in = 16'h1234;
        step(1);  load = 1'b0;
                  check("ld_pend",   16'(upd_pend), 16'h1);
        step(29); check("e63_pend",  16'(upd_pend), 16'h1);
        step(1);  check("e64_pend",  16'(upd_pend),   16'h0);
                  check("e64_tick",  16'(frame_tick), 16'h1);
        step(3);  check("d0_dig", 16'(dig_sel), 16'h1);
                  check("d0_seg", 16'(seg),     16'h66);
        step(8);  check("d1_dig", 16'(dig_sel), 16'h2);
                  check("d1_seg", 16'(seg),     16'h4F);
        step(8);  check("d2_seg", 16'(seg),     16'h5B);
        step(8);  check("d3_dig", 16'(dig_sel), 16'h8);
                  check("d3_seg", 16'(seg),     16'h06);

        // Two loads in one frame: only the latest reaches the display.
        load = 1'b1; value_in = 16'hAAAA;
        step(1);  value_in = 16'hBBBB;
        step(1);  load = 1'b0;
                  check("dbl_pend", 16'(upd_pend), 16'h1);
        step(3);  check("e96_tick", 16'(frame_tick), 16'h1);
        n77 = 0; n7c = 0;
        for (int i = 0; i < 32; i++) begin
            step(1);
            if (seg == 7'h77) n77++;
            if (seg == 7'h7C) n7c++;
        end
        check("no_77",  16'(n77), 16'd0);
        check("cnt_7c", 16'(n7c), 16'd24);

        // Leading-zero blanking.
        blank_lz = 1'b1;
        load = 1'b1; value_in = 16'h0050;
        step(1);  load = 1'b0;
        step(31); check("e160_tick", 16'(frame_tick), 16'h1);
        step(3);  check("lz0_seg", 16'(seg),     16'h3F);
        step(8);  check("lz1_seg", 16'(seg),     16'h6D);
        step(8);  check("lz2_dig", 16'(dig_sel), 16'h4);
                  check("lz2_seg", 16'(seg),     16'h00);
        step(8);  check("lz3_dig", 16'(dig_sel), 16'h8);
                  check("lz3_seg", 16'(seg),     16'h00);
        load = 1'b1; value_in = 16'h0000;
        step(1);  load = 1'b0;
        step(4);  check("e192_tick", 16'(frame_tick), 16'h1);
        step(3);  check("z0_seg", 16'(seg),     16'h3F);
        step(8);  check("z1_dig", 16'(dig_sel), 16'h2);
                  check("z1_seg", 16'(seg),     16'h00);
        step(16); check("z3_dig", 16'(dig_sel), 16'h8);
                  check("z3_seg", 16'(seg),     16'h00);

        // Pause at idx=2, cnt=5 for 20 cycles, loading while stopped.
        blank_lz = 1'b0;
        step(26);
        enable = 1'b0; load = 1'b1; value_in = 16'h0C00;
        step(1);  load = 1'b0;
                  check("off_dig",  16'(dig_sel),  16'h0);
                  check("off_seg",  16'(seg),      16'h00);
                  check("off_pend", 16'(upd_pend), 16'h1);
        step(1);  check("off_xfer", 16'(upd_pend), 16'h0);
        step(18); check("off_dig2",  16'(dig_sel),    16'h0);
                  check("off_tick",  16'(frame_tick), 16'h0);
        enable = 1'b1;
        step(1);  check("res_dig",  16'(dig_sel), 16'h4);
                  check("res_seg",  16'(seg),     16'h39);
        step(2);  check("res_dig7", 16'(dig_sel), 16'h4);
        step(1);  check("res_gap",  16'(dig_sel), 16'h0);
        step(2);  check("res_d3",   16'(dig_sel), 16'h8);
                  check("res_d3s",  16'(seg),     16'h3F);

        // Asynchronous reset between edges with a load pending.
        load = 1'b1; value_in = 16'h9999;
        step(1);  load = 1'b0;
                  check("pre_pend", 16'(upd_pend), 16'h1);
        blank_lz = 1'b1;
        #2 rst = 1'b1;
        #1;
        check("arst_seg",  16'(seg),      16'h00);
        check("arst_dig",  16'(dig_sel),  16'h0);
        check("arst_pend", 16'(upd_pend), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        step(3);  check("post_dig", 16'(dig_sel), 16'h1);
                  check("post_seg", 16'(seg),     16'h3F);
        step(8);  check("post_d1",  16'(dig_sel), 16'h2);
                  check("post_d1s", 16'(seg),     16'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
